fetch_stage: RTL

Instruction fetch stage: owns the program counter, issues word requests to the instruction cache/iTLB and delivers one `instr_t` at a time, with its PC, to the decode stage over a valid/ready handshake. Sits directly upstream of the decoder. It accepts redirects (taken branch, jump, iret, exception entry) from later stages and discards any wrong-path fetch in flight. Instruction-side translation faults are tagged and passed downstream, then fetching freezes until a redirect arrives.

---
 rtl/common_pkg.sv | 24 ++
 rtl/fetch_stage.sv | 116 +++++++++++
 2 files changed

// File: rtl/common_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Holds the word/instruction types, the fetch FSM state encoding,
// the boot address and the canonical nop used on faulting fetches.
package common;

  typedef logic [31:0] word_t;
  typedef logic [31:0] instr_t;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam word_t  BOOT_PC   = 32'h0000_1000;
  localparam instr_t NOP_INSTR = 32'h0000_0000;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic word_t align_word(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one icache request at a time, hands instr+pc to decode.
// Latency: output valid on the same edge the icache response arrives; 2 cycles/instr with a 1-cycle icache.
// Backpressure: no new request while the output register is full and decode is not consuming it.
module fetch_stage
  import common::*;
#(
  parameter word_t BOOT_PC = common::BOOT_PC
) (
  input  logic   clk,
  input  logic   rst_n,
  output logic   ic_req_valid,
  output word_t  ic_req_addr,
  input  logic   ic_req_ready,
  input  logic   ic_resp_valid,
  input  instr_t ic_resp_instr,
  input  logic   ic_resp_fault,
  input  logic   redirect_valid,
  input  word_t  redirect_pc,
  output logic   out_valid,
  input  logic   out_ready,
  output instr_t out_instr,
  output word_t  out_pc,
  output logic   out_fault
);

  fetch_state_t r_state;
  word_t        r_pc;
  logic         r_out_valid;
  instr_t       r_out_instr;
  word_t        r_out_pc;
  logic         r_out_fault;

  logic w_out_free;
  logic w_req_fire;
  logic w_load;

  // The output slot can take new data if empty or being drained this cycle.
  assign w_out_free   = !r_out_valid || out_ready;
  // Gated by rst_n so nothing is requested while the block is held in reset.
  assign ic_req_valid = rst_n && (r_state == REQ) && w_out_free && !redirect_valid;
  assign ic_req_addr  = r_pc;
  assign w_req_fire   = ic_req_valid && ic_req_ready;
  // A response only lands in the output when it belongs to the live path.
  assign w_load       = (r_state == WAIT) && ic_resp_valid && !redirect_valid;

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
  assign out_fault = r_out_fault;

  // Fetch FSM and program counter; a redirect overrides everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= REQ;
      r_pc    <= BOOT_PC;
    end else if (redirect_valid) begin
      r_pc <= align_word(redirect_pc);
      // A request still in flight must be drained unless its response is arriving now.
      if (((r_state == WAIT) || (r_state == DRAIN)) && !ic_resp_valid) begin
        r_state <= DRAIN;
      end else begin
        r_state <= REQ;
      end
    end else begin
      unique case (r_state)
        REQ: begin
          if (w_req_fire) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (ic_resp_valid) begin
            if (ic_resp_fault) begin
              // PC stays on the faulting address; only a redirect restarts fetch.
              r_state <= HALT;
            end else begin
              r_pc    <= r_pc + 32'd4;
              r_state <= REQ;
            end
          end
        end
        DRAIN: begin
          if (ic_resp_valid) begin
            r_state <= REQ;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= REQ;
        end
      endcase
    end
  end

  // Single-entry output register towards decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= NOP_INSTR;
      r_out_pc    <= '0;
      r_out_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_instr <= ic_resp_fault ? NOP_INSTR : ic_resp_instr;
      r_out_pc    <= r_pc;
      r_out_fault <= ic_resp_fault;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
